irq_collector: RTL and testbench

IRQ_COLLECTOR -- requirements
Module: irq_collector

---
 rtl/irq_pkg.sv | 15 +
 rtl/pencoder.sv | 21 ++
 rtl/irq_collector.sv | 75 +++++++
 tb/tb_irq_collector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizing and helpers for the interrupt collector slice.
package irq_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;

    typedef logic [NUM_SRC-1:0] src_vec_t;
    typedef logic [ID_W-1:0]    src_id_t;

    // One-hot decode of a source index.
    function automatic src_vec_t onehot(input src_id_t id);
        return src_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/pencoder.sv
// Combinational priority encoder: highest set index wins; id is zero when nothing is set.
module pencoder
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] cand_i,
    output logic [ID_W-1:0]    id_c_o,
    output logic               valid_c_o
);

    always_comb begin
        id_c_o    = '0;
        valid_c_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand_i[i]) begin
                id_c_o    = ID_W'(i);
                valid_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_collector.sv
// Collects edge/level interrupt requests into a sticky pending register and
// presents the highest-priority eligible source through a valid/ready slot.
module irq_collector
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               edge_mode,
    output logic [ID_W-1:0]    id_out,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] ovf,
    input  logic               ovf_clr
);

    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               valid_q, valid_d;

    logic [NUM_SRC-1:0] set_c, clr_c, cand_c, ovf_ev_c;
    logic               accept_c, load_c;
    logic [ID_W-1:0]    enc_id_c;
    logic               enc_valid_c;

    // Candidates come from last cycle's pending, so a freshly set bit waits one cycle.
    always_comb begin
        set_c    = edge_mode ? (req & ~req_q) : req;
        accept_c = valid_q & id_ready;
        clr_c    = accept_c ? onehot(id_q) : '0;
        cand_c   = pending_q & mask & ~clr_c;
        load_c   = ~valid_q | accept_c;
    end

    pencoder u_pencoder (
        .cand_i    (cand_c),
        .id_c_o    (enc_id_c),
        .valid_c_o (enc_valid_c)
    );

    // An edge landing on its own clear re-pends without counting as lost.
    always_comb begin
        ovf_ev_c  = edge_mode ? (set_c & pending_q & ~clr_c) : '0;
        pending_d = (pending_q & ~clr_c) | set_c;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_ev_c;
        id_d      = load_c ? enc_id_c : id_q;
        valid_d   = load_c ? enc_valid_c : valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
        end
    end

    assign id_out   = id_q;
    assign id_valid = valid_q;
    assign pending  = pending_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_collector.sv
// Directed table-driven bench for irq_collector plus burst and level-stall sequences.
module tb_irq_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       edge_mode;
    logic [1:0] id_out;
    logic       id_valid;
    logic       id_ready;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_collector dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .edge_mode (edge_mode),
        .id_out    (id_out),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic       em;
        logic       rdy;
        logic       oc;
        logic [1:0] e_id;
        logic       e_valid;
        logic [3:0] e_pend;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic r, input logic [3:0] rq,
                                input logic [3:0] mk, input logic em, input logic rdy,
                                input logic oc, input logic [1:0] eid, input logic ev,
                                input logic [3:0] ep, input logic [3:0] eo);
        vec_t v;
        v.name = name; v.rst = r; v.req = rq; v.mask = mk; v.em = em; v.rdy = rdy; v.oc = oc;
        v.e_id = eid; v.e_valid = ev; v.e_pend = ep; v.e_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] eid, input logic ev,
                         input logic [3:0] ep, input logic [3:0] eo);
        checks++;
        if (id_out !== eid || id_valid !== ev || pending !== ep || ovf !== eo) begin
            errors++;
            $display("FAIL %s: got id=%b v=%b pend=%b ovf=%b, want id=%b v=%b pend=%b ovf=%b",
                     name, id_out, id_valid, pending, ovf, eid, ev, ep, eo);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] mk,
                         input logic em, input logic rdy, input logic oc);
        rst = r; req = rq; mask = mk; edge_mode = em; id_ready = rdy; ovf_clr = oc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; mask = '1; edge_mode = 1'b1; id_ready = 1'b1; ovf_clr = 1'b0;
        @(negedge clk);

        //  name        rst req      mask     em   rdy  oc   id     v    pend     ovf
        add("reset",    1, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("idle",     0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("a_set",    0, 4'b0100, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0100, 4'b0000);
        add("a_pres",   0, 4'b0000, 4'b1111, 1, 1, 0, 2'b10, 1, 4'b0100, 4'b0000);
        add("a_acc",    0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("a_idle",   0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("b_set0",   0, 4'b0001, 4'b1111, 1, 0, 0, 2'b00, 0, 4'b0001, 4'b0000);
        add("b_pres0",  0, 4'b0000, 4'b1111, 1, 0, 0, 2'b00, 1, 4'b0001, 4'b0000);
        add("b_set3",   0, 4'b1000, 4'b1111, 1, 0, 0, 2'b00, 1, 4'b1001, 4'b0000);
        add("b_hold",   0, 4'b0000, 4'b1111, 1, 0, 0, 2'b00, 1, 4'b1001, 4'b0000);
        add("b_acc0",   0, 4'b0000, 4'b1111, 1, 1, 0, 2'b11, 1, 4'b1000, 4'b0000);
        add("b_acc3",   0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("c_set",    0, 4'b0010, 4'b1111, 1, 0, 0, 2'b00, 0, 4'b0010, 4'b0000);
        add("c_pres",   0, 4'b0000, 4'b1111, 1, 0, 0, 2'b01, 1, 4'b0010, 4'b0000);
        add("c_ovf",    0, 4'b0010, 4'b1111, 1, 0, 0, 2'b01, 1, 4'b0010, 4'b0010);
        add("c_oclr",   0, 4'b0000, 4'b1111, 1, 0, 1, 2'b01, 1, 4'b0010, 4'b0000);
        add("c_edgacc", 0, 4'b0010, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0010, 4'b0000);
        add("c_repres", 0, 4'b0000, 4'b1111, 1, 1, 0, 2'b01, 1, 4'b0010, 4'b0000);
        add("c_acc",    0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("c2_set",   0, 4'b0010, 4'b1111, 1, 0, 0, 2'b00, 0, 4'b0010, 4'b0000);
        add("c2_pres",  0, 4'b0000, 4'b1111, 1, 0, 0, 2'b01, 1, 4'b0010, 4'b0000);
        add("c2_ovfwin",0, 4'b0010, 4'b1111, 1, 0, 1, 2'b01, 1, 4'b0010, 4'b0010);
        add("c2_oclr",  0, 4'b0000, 4'b1111, 1, 0, 1, 2'b01, 1, 4'b0010, 4'b0000);
        add("c2_acc",   0, 4'b0000, 4'b1111, 1, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("d_set",    0, 4'b0011, 4'b1111, 0, 1, 0, 2'b00, 0, 4'b0011, 4'b0000);
        add("d_id1",    0, 4'b0011, 4'b1111, 0, 1, 0, 2'b01, 1, 4'b0011, 4'b0000);
        add("d_id0",    0, 4'b0011, 4'b1111, 0, 1, 0, 2'b00, 1, 4'b0011, 4'b0000);
        add("d_id1b",   0, 4'b0011, 4'b1111, 0, 1, 0, 2'b01, 1, 4'b0011, 4'b0000);
        add("d_id0b",   0, 4'b0011, 4'b1111, 0, 1, 0, 2'b00, 1, 4'b0011, 4'b0000);
        add("d_drain1", 0, 4'b0000, 4'b1111, 0, 1, 0, 2'b01, 1, 4'b0010, 4'b0000);
        add("d_drain2", 0, 4'b0000, 4'b1111, 0, 1, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("e_mask0",  0, 4'b1111, 4'b0000, 1, 1, 0, 2'b00, 0, 4'b1111, 4'b0000);
        add("e_mask0b", 0, 4'b1111, 4'b0000, 1, 1, 0, 2'b00, 0, 4'b1111, 4'b0000);
        add("e_mask2",  0, 4'b1111, 4'b0100, 1, 1, 0, 2'b10, 1, 4'b1111, 4'b0000);
        add("e_nowdraw",0, 4'b1111, 4'b0000, 1, 0, 0, 2'b10, 1, 4'b1111, 4'b0000);
        add("e_acc",    0, 4'b1111, 4'b0000, 1, 1, 0, 2'b00, 0, 4'b1011, 4'b0000);
        add("f_pres0",  0, 4'b1111, 4'b0001, 1, 1, 0, 2'b00, 1, 4'b1011, 4'b0000);
        add("f_pres3",  0, 4'b1111, 4'b1000, 1, 1, 0, 2'b11, 1, 4'b1010, 4'b0000);
        add("f_rst",    1, 4'b0001, 4'b1111, 1, 0, 0, 2'b00, 0, 4'b0000, 4'b0000);
        add("f_rel1",   0, 4'b0001, 4'b1111, 1, 0, 0, 2'b00, 0, 4'b0001, 4'b0000);
        add("f_rel2",   0, 4'b0001, 4'b1111, 1, 0, 0, 2'b00, 1, 4'b0001, 4'b0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].em, vecs[i].rdy, vecs[i].oc);
            check(vecs[i].name, vecs[i].e_id, vecs[i].e_valid, vecs[i].e_pend, vecs[i].e_ovf);
        end

        // Burst: all four sources pend at once, delivered highest first with no bubble.
        drive(1, 4'b0000, 4'b1111, 1, 1, 0);
        drive(0, 4'b1111, 4'b1111, 1, 1, 0);
        check("burst_set", 2'b00, 0, 4'b1111, 4'b0000);
        begin
            int budget = 5;
            req = 4'b0000;
            while (budget > 0 && id_valid !== 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                budget--;
            end
            checks++;
            if (id_valid !== 1'b1) begin
                errors++;
                $display("FAIL burst_wait: id_valid never asserted within budget");
            end
        end
        for (int k = 3; k >= 0; k--) begin
            logic [3:0] exp_pend;
            exp_pend = 4'((1 << (k + 1)) - 1);
            check($sformatf("burst_id%0d", k), 2'(k), 1, exp_pend, 4'b0000);
            @(posedge clk);
            @(negedge clk);
        end
        check("burst_done", 2'b00, 0, 4'b0000, 4'b0000);

        // Level mode: a held request under stall never overflows.
        drive(0, 4'b0100, 4'b1111, 0, 0, 0);
        check("lvl_set", 2'b00, 0, 4'b0100, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'b0100, 4'b1111, 0, 0, 0);
            check($sformatf("lvl_stall%0d", k), 2'b10, 1, 4'b0100, 4'b0000);
        end
        drive(0, 4'b0100, 4'b1111, 0, 1, 0);
        check("lvl_acc", 2'b00, 0, 4'b0100, 4'b0000);
        drive(0, 4'b0000, 4'b1111, 0, 1, 0);
        check("lvl_repres", 2'b10, 1, 4'b0100, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
